// File: rtl/simon_out_packer.sv
// simon_out_packer: gathers SIMON cipher blocks into tagged packets
// and buffers finished packets in a small output FIFO.
module simon_out_packer #(
    parameter int N = 32,
    parameter int BPP = 2,
    parameter int DEPTH = 2,
    parameter logic [3:0] MODE = 4'h0,
    localparam int PKT_W = 16 + 2 * BPP * N,
    localparam int FW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  R,
    input  logic                  doneDATA,
    input  logic [7:0]            infoOUT,
    input  logic [1:0][N-1:0]     outDATA,
    output logic                  readDATA,
    input  logic                  out_readPKT,
    output logic                  out_donePKT,
    output logic [PKT_W-1:0]      out,
    output logic                  err,
    output logic [FW-1:0]         fill
);

    localparam int KW = $clog2(BPP + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, READ, DROP, RELEASE, PUSH
    } state_t;

    state_t                    state_q, state_d;
    logic                      open_q, open_d;
    logic [7:0]                info_q, info_d;
    logic [KW-1:0]             k_q, k_d;
    logic [KW-1:0]             need_q, need_d;
    logic [2*BPP-1:0][N-1:0]   slot_q, slot_d;
    logic [7:0]                count_q, count_d;
    logic [DEPTH-1:0][PKT_W-1:0] mem_q, mem_d;
    logic [PW-1:0]             wr_q, wr_d;
    logic [PW-1:0]             rd_q, rd_d;
    logic [FW-1:0]             fill_q, fill_d;
    logic                      full;
    logic                      push;
    logic                      pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Push is gated by the registered full flag only, never by a same-cycle pop.
    assign full        = (fill_q == FW'(DEPTH));
    assign out_donePKT = (fill_q != '0);
    assign pop         = out_donePKT & out_readPKT;
    assign push        = (state_q == PUSH) & ~full;
    assign readDATA    = (state_q == READ) | (state_q == DROP);
    assign err         = (state_q == DROP);
    assign fill        = fill_q;
    assign out         = out_donePKT ? mem_q[rd_q] : '0;

    always_comb begin
        state_d = state_q;
        open_d  = open_q;
        info_d  = info_q;
        k_d     = k_q;
        need_d  = need_q;
        slot_d  = slot_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (doneDATA) state_d = open_q ? READ : LOAD;
            end
            LOAD: begin
                if (infoOUT[3:0] != MODE || !infoOUT[4]) begin
                    state_d = DROP;
                end else begin
                    info_d  = infoOUT;
                    need_d  = (infoOUT[7] & ~infoOUT[5]) ? KW'(BPP) : KW'(1);
                    k_d     = '0;
                    open_d  = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                for (int i = 0; i < BPP; i++) begin
                    if (k_q == KW'(i)) begin
                        if (info_q[5]) begin
                            slot_d[2*i]   = '0;
                            slot_d[2*i+1] = '0;
                        end else if (info_q[6]) begin
                            slot_d[2*i]   = outDATA[0];
                            slot_d[2*i+1] = outDATA[1];
                        end else begin
                            slot_d[2*i]   = outDATA[1];
                            slot_d[2*i+1] = outDATA[0];
                        end
                    end
                end
                k_d     = k_q + KW'(1);
                state_d = RELEASE;
            end
            DROP: state_d = RELEASE;
            RELEASE: begin
                if (!doneDATA) begin
                    state_d = (open_q && k_q == need_q) ? PUSH : IDLE;
                end
            end
            PUSH: begin
                if (!full) begin
                    count_d = count_q + 8'd1;
                    slot_d  = '0;
                    open_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        fill_d = fill_q;
        if (push) begin
            mem_d[wr_q] = {info_q, count_q, slot_q};
            wr_d        = ptr_next(wr_q);
        end
        if (pop) rd_d = ptr_next(rd_q);
        if (push && !pop) fill_d = fill_q + FW'(1);
        else if (pop && !push) fill_d = fill_q - FW'(1);
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q <= IDLE;
            open_q  <= 1'b0;
            info_q  <= '0;
            k_q     <= '0;
            need_q  <= '0;
            slot_q  <= '0;
            count_q <= '0;
            mem_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            open_q  <= open_d;
            info_q  <= info_d;
            k_q     <= k_d;
            need_q  <= need_d;
            slot_q  <= slot_d;
            count_q <= count_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fill_q  <= fill_d;
        end
    end

endmodule
